// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit simple processor control path:
// opcodes, step encoding and instruction-word field positions.
package proc_pkg;

    localparam int unsigned WIDTH   = 9;
    localparam int unsigned NREG    = 8;
    localparam int unsigned FIELD_W = 3;

    localparam int unsigned OP_LSB = 6;
    localparam int unsigned RX_LSB = 3;
    localparam int unsigned RY_LSB = 0;

    localparam logic [FIELD_W-1:0] OP_MV   = 3'b000;
    localparam logic [FIELD_W-1:0] OP_MVI  = 3'b001;
    localparam logic [FIELD_W-1:0] OP_ADD  = 3'b010;
    localparam logic [FIELD_W-1:0] OP_SUB  = 3'b011;
    localparam logic [FIELD_W-1:0] OP_MVNZ = 3'b100;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    function automatic logic [FIELD_W-1:0] ir_field(input logic [WIDTH-1:0] ir,
                                                    input int unsigned lsb);
        return ir[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// Control-unit bundle: instruction/status inputs from the datapath and the
// load/select strobes driven back into it.
interface proc_ctrl_fsm_if;
    import proc_pkg::*;

    logic             Run;
    logic [WIDTH-1:0] IR;
    logic             Gnz;
    logic             IRin;
    logic [NREG-1:0]  Rin;
    logic [NREG-1:0]  Rout;
    logic             DINout;
    logic             Gout;
    logic             Ain;
    logic             Gin;
    logic             AddSub;
    logic             Done;

    modport master (
        output Run, IR, Gnz,
        input  IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done
    );

    modport slave (
        input  Run, IR, Gnz,
        output IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done
    );

endinterface

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module dec3to8 (
    input  logic [2:0] w_i,
    input  logic       en_i,
    output logic [7:0] y_o
);

    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[w_i] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// T0-T3 step sequencer for the simple processor; decodes IR into register
// load enables, one-hot bus-source selects and ALU controls.
module proc_ctrl_fsm
    import proc_pkg::*;
(
    input  logic          Clock,
    input  logic          Reset,
    proc_ctrl_fsm_if.slave bus
);

    step_e state_q, state_d;

    logic [FIELD_W-1:0] op, rx, ry, rout_sel;
    logic               irin_c, din_c, gout_c, ain_c, gin_c, addsub_c, done_c;
    logic               rin_en_c, rout_en_c, rout_rx_c;
    logic [NREG-1:0]    rin_c, rout_c;

    assign op = ir_field(bus.IR, OP_LSB);
    assign rx = ir_field(bus.IR, RX_LSB);
    assign ry = ir_field(bus.IR, RY_LSB);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next step and strobes; Reset gates everything so outputs drop without an edge.
    always_comb begin
        state_d   = state_q;
        irin_c    = 1'b0;
        din_c     = 1'b0;
        gout_c    = 1'b0;
        ain_c     = 1'b0;
        gin_c     = 1'b0;
        addsub_c  = 1'b0;
        done_c    = 1'b0;
        rin_en_c  = 1'b0;
        rout_en_c = 1'b0;
        rout_rx_c = 1'b0;
        if (!Reset) begin
            case (state_q)
                T0: begin
                    irin_c  = bus.Run;
                    state_d = bus.Run ? T1 : T0;
                end
                T1: begin
                    state_d = T0;
                    case (op)
                        OP_MV: begin
                            rout_en_c = 1'b1;
                            rin_en_c  = 1'b1;
                            done_c    = 1'b1;
                        end
                        OP_MVI: begin
                            din_c    = 1'b1;
                            rin_en_c = 1'b1;
                            done_c   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            rout_en_c = 1'b1;
                            rout_rx_c = 1'b1;
                            ain_c     = 1'b1;
                            state_d   = T2;
                        end
                        OP_MVNZ: begin
                            rout_en_c = bus.Gnz;
                            rin_en_c  = bus.Gnz;
                            done_c    = 1'b1;
                        end
                        default: done_c = 1'b1;
                    endcase
                end
                T2: begin
                    rout_en_c = 1'b1;
                    gin_c     = 1'b1;
                    addsub_c  = (op == OP_SUB);
                    state_d   = T3;
                end
                T3: begin
                    gout_c   = 1'b1;
                    rin_en_c = 1'b1;
                    done_c   = 1'b1;
                    state_d  = T0;
                end
                default: state_d = T0;
            endcase
        end
    end

    // Rx feeds the bus only for the A-load step of add/sub.
    assign rout_sel = rout_rx_c ? rx : ry;

    dec3to8 u_dec_rin (
        .w_i  (rx),
        .en_i (rin_en_c),
        .y_o  (rin_c)
    );

    dec3to8 u_dec_rout (
        .w_i  (rout_sel),
        .en_i (rout_en_c),
        .y_o  (rout_c)
    );

    assign bus.IRin   = irin_c;
    assign bus.Rin    = rin_c;
    assign bus.Rout   = rout_c;
    assign bus.DINout = din_c;
    assign bus.Gout   = gout_c;
    assign bus.Ain    = ain_c;
    assign bus.Gin    = gin_c;
    assign bus.AddSub = addsub_c;
    assign bus.Done   = done_c;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed bench for proc_ctrl_fsm: each step's strobes are compared
// against hand-derived vectors.
module tb_proc_ctrl_fsm;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    proc_ctrl_fsm_if bus ();

    proc_ctrl_fsm dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done}
    function automatic logic [22:0] outs();
        return {bus.IRin, bus.Rin, bus.Rout, bus.DINout, bus.Gout,
                bus.Ain, bus.Gin, bus.AddSub, bus.Done};
    endfunction

    function automatic logic [22:0] ev(input logic irin, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic din,
                                       input logic gout, input logic ain,
                                       input logic gin, input logic addsub,
                                       input logic done);
        return {irin, rin, rout, din, gout, ain, gin, addsub, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] e;
        rst = 1'b1; bus.Run = 1'b1; bus.IR = 9'b001_000_000; bus.Gnz = 1'b0;
        tick(); tick();
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL reset_hold: got %h want %h", outs(), e); end
        bus.Run = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (outs() !== e) begin errors++; $display("FAIL reset_idle: got %h want %h", outs(), e); end
    endtask

    task automatic test_mvi();
        logic [22:0] e;
        bus.Run = 1'b1; bus.IR = 9'b001_000_000;
        #1;
        e = ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL mvi_t0: got %h want %h", outs(), e); end
        tick();
        e = ev(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1);
        checks++; if (outs() !== e) begin errors++; $display("FAIL mvi_t1: got %h want %h", outs(), e); end
        bus.Run = 1'b0;
        tick();
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL mvi_back_t0: got %h want %h", outs(), e); end
    endtask

    task automatic test_mv();
        logic [22:0] e;
        bus.Run = 1'b1; bus.IR = 9'b000_011_101;
        tick();
        e = ev(0, 8'h08, 8'h20, 0, 0, 0, 0, 0, 1);
        checks++; if (outs() !== e) begin errors++; $display("FAIL mv_t1: got %h want %h", outs(), e); end
        tick();
        e = ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL mv_next_fetch: got %h want %h", outs(), e); end
    endtask

    // Enters in T0 with Run high from the previous instruction.
    task automatic test_back_to_back();
        logic [22:0] e;
        bus.IR = 9'b010_001_010;
        tick();
        e = ev(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL add_t1: got %h want %h", outs(), e); end
        tick();
        e = ev(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL add_t2: got %h want %h", outs(), e); end
        tick();
        e = ev(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1);
        checks++; if (outs() !== e) begin errors++; $display("FAIL add_t3: got %h want %h", outs(), e); end
        tick();
        e = ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL b2b_t0: got %h want %h", outs(), e); end
        bus.IR = 9'b011_111_000;
        tick();
        e = ev(0, 8'h00, 8'h80, 0, 0, 1, 0, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL sub_t1: got %h want %h", outs(), e); end
        tick();
        e = ev(0, 8'h00, 8'h01, 0, 0, 0, 1, 1, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL sub_t2: got %h want %h", outs(), e); end
        bus.Run = 1'b0;
        tick();
        e = ev(0, 8'h80, 8'h00, 0, 1, 0, 0, 0, 1);
        checks++; if (outs() !== e) begin errors++; $display("FAIL sub_t3: got %h want %h", outs(), e); end
        tick();
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL sub_end_t0: got %h want %h", outs(), e); end
    endtask

    task automatic test_mvnz();
        logic [22:0] e;
        bus.Run = 1'b1; bus.Gnz = 1'b0; bus.IR = 9'b100_100_110;
        tick();
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
        checks++; if (outs() !== e) begin errors++; $display("FAIL mvnz_g0_t1: got %h want %h", outs(), e); end
        tick();
        bus.Gnz = 1'b1;
        tick();
        e = ev(0, 8'h10, 8'h40, 0, 0, 0, 0, 0, 1);
        checks++; if (outs() !== e) begin errors++; $display("FAIL mvnz_g1_t1: got %h want %h", outs(), e); end
        bus.Run = 1'b0; bus.Gnz = 1'b0;
        tick();
    endtask

    task automatic test_illegal_idle();
        logic [22:0] e;
        bus.Run = 1'b1; bus.IR = 9'b111_010_101;
        tick();
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
        checks++; if (outs() !== e) begin errors++; $display("FAIL illegal_t1: got %h want %h", outs(), e); end
        bus.Run = 1'b0;
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (outs() !== e) begin errors++; $display("FAIL idle_%0d: got %h want %h", i, outs(), e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [22:0] e;
        bus.Run = 1'b1; bus.IR = 9'b010_001_010;
        tick(); tick();
        e = ev(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL rst_pre_t2: got %h want %h", outs(), e); end
        rst = 1'b1;
        #1;
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL rst_async_drop: got %h want %h", outs(), e); end
        tick();
        checks++; if (outs() !== e) begin errors++; $display("FAIL rst_no_done: got %h want %h", outs(), e); end
        rst = 1'b0;
        bus.IR = 9'b001_000_000;
        #1;
        e = ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        checks++; if (outs() !== e) begin errors++; $display("FAIL rst_release_fetch: got %h want %h", outs(), e); end
        tick();
        e = ev(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1);
        checks++; if (outs() !== e) begin errors++; $display("FAIL rst_resume_t1: got %h want %h", outs(), e); end
        bus.Run = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_mv();
        test_back_to_back();
        test_mvnz();
        test_illegal_idle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

Control unit for the 9-bit simple processor. Consumes the instruction word held in the instruction register and sequences the datapath through a T0–T3 step counter. Drives the register-load enables, the one-hot bus-source selects for the bus multiplexer, the A/G register loads and the add/subtract mode. Sits directly upstream of the register file, bus mux and add/sub unit, and signals instruction completion on Done.

## Interface
- WIDTH, 9, instruction/data width; only 9 is supported because the field positions are fixed.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  request to fetch and execute an instruction; sampled only in T0.
- IR  in  WIDTH  instruction word: IR[8:6]=opcode III, IR[5:3]=Rx, IR[2:0]=Ry.
- Gnz  in  1  high when register G holds a nonzero value; used by mvnz.
- IRin  out  1  load enable for the instruction register.
- Rin  out  8  one-hot load enables for R0–R7.
- Rout  out  8  one-hot bus-source selects for R0–R7.
- DINout  out  1  drive DIN onto the bus.
- Gout  out  1  drive G onto the bus.
- Ain  out  1  load enable for the A register.
- Gin  out  1  load enable for the G register.
- AddSub  out  1  0 = add, 1 = subtract.
- Done  out  1  one-cycle pulse in the final step of every instruction.
- One clock; reset is asynchronous and active-high (ports Clock and Reset).

## Operation
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#DIN
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 100 mvnz Rx,Ry
  - 101–111 illegal
- States:
  - T0: IRin = Run. If Run, go to T1; otherwise stay in T0.
  - T1, mv: Rout[Ry], Rin[Rx], Done; go to T0.
  - T1, mvi: DINout, Rin[Rx], Done; go to T0.
  - T1, add/sub: Rout[Rx], Ain; go to T2.
  - T1, mvnz: if Gnz, Rout[Ry] and Rin[Rx]; Done in either case; go to T0.
  - T1, illegal: Done only, with no register writes; go to T0.
  - T2: Rout[Ry], Gin, AddSub = (opcode == 011); go to T3.
  - T3: Gout, Rin[Rx], Done; go to T0.
- Outputs are combinational in (state, IR, Run, Gnz). Every output not listed for the current step is 0.
- Rin and Rout are always one-hot or zero. At most one bus source is active in any cycle (Rout bits, DINout, Gout).
- IR is stable from T1 through T3, because IRin is asserted only in T0.
- Run is ignored outside T0. An instruction in flight always completes unless Reset is asserted.
- Rx == Ry is legal. For example, add R2,R2 is allowed; the datapath handles the doubling.

## Timing
- Reset value: state T0; every output 0. Reset forces all outputs to 0 asynchronously, including IRin regardless of Run.
- Reset mid-instruction: the FSM returns to T0 immediately, with no Done and no register writes. Fetch resumes on the first edge after Reset deasserts, if Run is high in T0.
- Latency from the T0 fetch cycle to the Done cycle inclusive:
  - mv, mvi, mvnz and illegal: 2 cycles.
  - add and sub: 4 cycles.
- Back-to-back execution: with Run held high, the cycle after Done is T0 with IRin=1. Throughput is one instruction per 2 or 4 cycles, with no bubble.
- Done stays high for exactly one cycle per instruction.

## Structure
- Shared package proc_pkg holds:
  - the opcode localparams OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ;
  - the step enum typedef (T0, T1, T2, T3), 2-bit encoded;
  - the IR field-position constants.
- Rx and Ry are decoded to one-hot with two instances of the existing dec3to8 sub-module. Its EN input is driven by the step/opcode qualifiers, so Rin and Rout are zero whenever they are not used.
- Implementation: one always_ff holds the step register; one always_comb computes next-state and outputs.

## Test plan
- mvi R0: Run=1, IR=001_000_000 -> T0: IRin=1; T1: DINout=1, Rin=8'h01, Done=1; next cycle is T0.
- mv R3,R5: IR=000_011_101 -> T1: Rout=8'h20, Rin=8'h08, Done=1; Ain, Gin and Gout all 0.
- add R1,R2 then sub R7,R0 with Run held high:
  - add, IR=010_001_010 -> T1: Rout=8'h02, Ain. T2: Rout=8'h04, Gin, AddSub=0. T3: Gout, Rin=8'h02, Done.
  - sub, IR=011_111_000, starts the next cycle -> T2: Rout=8'h01, AddSub=1. T3: Rin=8'h80.
- mvnz R4,R6: IR=100_100_110.
  - With Gnz=0 -> T1: Rin=0, Rout=0, Done=1.
  - Repeated with Gnz=1 -> T1: Rout=8'h40, Rin=8'h10, Done=1.
- Illegal opcode and idle:
  - IR=111_xxx_xxx -> T1: Done=1 only, then T0.
  - Run=0 for 5 cycles -> stays in T0 with all outputs 0.
- Reset in T2 of add: outputs drop to 0 before the next edge, and no Done appears. After release with Run=1, IRin=1 in the first cycle.
